// File: rtl/mmio_req_queue.sv
// rtl/mmio_req_queue.sv - CCI-P c0 MMIO request queue feeding the AFU register file
//
// Captures MMIO read/write requests from CCI-P RX channel 0 into a FIFO and
// presents the head entry to the register file through a valid/ready handshake.
// MMIO cannot be back-pressured, so requests arriving at a full queue are
// dropped and recorded in a sticky overflow flag and a saturating drop counter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rx_mmio_wr_valid/rd_valid  request strobes (both high is illegal; write wins)
//   rx_mmio_addr/tid/data    request header fields and write data
//   req_valid/req_ready      head-entry handshake towards the register file
//   req_is_wr/addr/tid/data  head entry (data is 0 for reads, all 0 when empty)
//   q_count                  current occupancy, 0..DEPTH
//   overflow, drop_cnt       sticky drop flag and saturating drop counter
//   status_clr               clears overflow and drop_cnt
module mmio_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int TID_W  = 9,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_mmio_wr_valid,
    input  logic                       rx_mmio_rd_valid,
    input  logic [ADDR_W-1:0]          rx_mmio_addr,
    input  logic [TID_W-1:0]           rx_mmio_tid,
    input  logic [DATA_W-1:0]          rx_mmio_data,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic                       req_is_wr,
    output logic [ADDR_W-1:0]          req_addr,
    output logic [TID_W-1:0]           req_tid,
    output logic [DATA_W-1:0]          req_data,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt,
    input  logic                       status_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + TID_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             push, dual, full, empty, pop, accept;
    logic [1:0]       n_drop;
    logic [ENT_W-1:0] new_entry;
    logic [ENT_W-1:0] head;
    logic [15:0]      drop_base;
    logic [16:0]      drop_sum;

    always_comb begin
        push   = rx_mmio_wr_valid | rx_mmio_rd_valid;
        dual   = rx_mmio_wr_valid & rx_mmio_rd_valid;
        full   = (count_q == CNT_W'(DEPTH));
        empty  = (count_q == '0);
        pop    = ~empty & req_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        accept = push & (~full | pop);

        // Rejected push costs one drop; the illegal read of a dual strobe costs
        // another, so a dual strobe into a blocked queue counts two.
        n_drop = {1'b0, push & ~accept} + {1'b0, dual};

        // Write wins a dual strobe, so is_wr is just the write strobe.
        new_entry = {rx_mmio_wr_valid, rx_mmio_addr, rx_mmio_tid,
                     rx_mmio_wr_valid ? rx_mmio_data : {DATA_W{1'b0}}};

        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear is applied first, then any drop of the same cycle lands on top.
        drop_base  = status_clr ? 16'h0000 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = (overflow_q & ~status_clr) | (n_drop != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset so it can map to RAM; stale contents are never
    // visible because the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_comb begin
        head      = empty ? {ENT_W{1'b0}} : mem_q[rd_ptr_q];
        req_valid = ~empty;
        req_is_wr = head[ENT_W-1];
        req_addr  = head[TID_W+DATA_W +: ADDR_W];
        req_tid   = head[DATA_W +: TID_W];
        req_data  = head[DATA_W-1:0];
        q_count   = count_q;
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_mmio_req_queue.sv
// tb/tb_mmio_req_queue.sv - scoreboard testbench for mmio_req_queue
module tb_mmio_req_queue;

    typedef logic [89:0] ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [15:0] addr = '0;
    logic [8:0]  tid = '0;
    logic [63:0] data = '0;
    logic        req_valid, req_ready = 1'b0;
    logic        req_is_wr;
    logic [15:0] req_addr;
    logic [8:0]  req_tid;
    logic [63:0] req_data;
    logic [3:0]  q_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        status_clr = 1'b0;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mmio_req_queue #(.DEPTH(8), .ADDR_W(16), .TID_W(9), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_mmio_wr_valid (wr),
        .rx_mmio_rd_valid (rd),
        .rx_mmio_addr     (addr),
        .rx_mmio_tid      (tid),
        .rx_mmio_data     (data),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_wr        (req_is_wr),
        .req_addr         (req_addr),
        .req_tid          (req_tid),
        .req_data         (req_data),
        .q_count          (q_count),
        .overflow         (overflow),
        .drop_cnt         (drop_cnt),
        .status_clr       (status_clr)
    );

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic ent_t ent(input logic w, input logic [15:0] a,
                                 input logic [8:0] t, input logic [63:0] d);
        return {w, a, t, w ? d : 64'h0};
    endfunction

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin : monitor
        ent_t e;
        if (rst && req_valid && req_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 96'(1), 96'(0));
            end else begin
                e = sb.pop_front();
                chk("head_entry", 96'({req_is_wr, req_addr, req_tid, req_data}), 96'(e));
            end
        end
    end

    task automatic push(input logic w, input logic r, input logic [15:0] a,
                        input logic [8:0] t, input logic [63:0] d);
        wr = w; rd = r; addr = a; tid = t; data = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        req_ready = 1'b1;
        while ((sb.size() != 0 || req_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_sb_empty", 96'(sb.size()), 96'(0));
        chk("drain_q_count", 96'(q_count), 96'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset state and mid-operation reset ----
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", 96'(req_valid), 96'(0));
        chk("rst_count", 96'(q_count), 96'(0));
        chk("rst_addr", 96'(req_addr), 96'(0));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 16'h0100 + 16'(i), 9'(1 + i), 64'h0);
        chk("t1_count3", 96'(q_count), 96'(3));
        #3 rst = 1'b0;
        #1;
        chk("t1_async_valid", 96'(req_valid), 96'(0));
        chk("t1_async_count", 96'(q_count), 96'(0));
        chk("t1_async_tid", 96'(req_tid), 96'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        chk("t1_overflow", 96'(overflow), 96'(0));
        chk("t1_drop_cnt", 96'(drop_cnt), 96'(0));
        wr = 1'b1; addr = 16'h000A; tid = 9'h003; data = 64'hAA;
        @(negedge clk);
        chk("t1_no_fallthrough", 96'(req_valid), 96'(0));
        @(posedge clk); #1;
        wr = 1'b0;
        sb.push_back(ent(1'b1, 16'h000A, 9'h003, 64'hAA));
        chk("t1_latency_valid", 96'(req_valid), 96'(1));
        chk("t1_latency_count", 96'(q_count), 96'(1));

        // ---- 2: write then read, in order ----
        req_ready = 1'b1;
        sb.push_back(ent(1'b1, 16'h000C, 9'h005, 64'h1234123412341234));
        push(1'b1, 1'b0, 16'h000C, 9'h005, 64'h1234123412341234);
        chk("t2_wr_head_tid", 96'(req_tid), 96'(9'h005));
        chk("t2_wr_head_is_wr", 96'(req_is_wr), 96'(1));
        sb.push_back(ent(1'b0, 16'h000C, 9'h006, 64'h0));
        push(1'b0, 1'b1, 16'h000C, 9'h006, 64'hDEADBEEF);
        chk("t2_rd_head_tid", 96'(req_tid), 96'(9'h006));
        chk("t2_rd_head_data", 96'(req_data), 96'(0));
        wait_drain();

        // ---- 3: overflow with 10 reads into 8 entries ----
        req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(ent(1'b0, 16'h0200, 9'(9'h040 + i), 64'h0));
            push(1'b0, 1'b1, 16'h0200, 9'(9'h040 + i), 64'h0);
        end
        chk("t3_count", 96'(q_count), 96'(8));
        chk("t3_overflow", 96'(overflow), 96'(1));
        chk("t3_drop_cnt", 96'(drop_cnt), 96'(2));
        wait_drain();

        // ---- 4: push and pop together while full ----
        req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ent(1'b1, 16'h0300, 9'(9'h060 + i), 64'(i)));
            push(1'b1, 1'b0, 16'h0300, 9'(9'h060 + i), 64'(i));
        end
        chk("t4_full", 96'(q_count), 96'(8));
        req_ready = 1'b1;
        sb.push_back(ent(1'b1, 16'h0304, 9'h070, 64'h77));
        push(1'b1, 1'b0, 16'h0304, 9'h070, 64'h77);
        req_ready = 1'b0;
        chk("t4_count_kept", 96'(q_count), 96'(8));
        chk("t4_no_drop", 96'(drop_cnt), 96'(2));
        chk("t4_new_head", 96'(req_tid), 96'(9'h061));
        wait_drain();

        // ---- 5: dual strobe, then clear coinciding with a drop ----
        req_ready = 1'b0;
        status_clr = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        chk("t5_clr_overflow", 96'(overflow), 96'(0));
        chk("t5_clr_drop_cnt", 96'(drop_cnt), 96'(0));
        sb.push_back(ent(1'b1, 16'h0040, 9'h011, 64'hCAFE));
        push(1'b1, 1'b1, 16'h0040, 9'h011, 64'hCAFE);
        chk("t5_dual_count", 96'(q_count), 96'(1));
        chk("t5_dual_drop", 96'(drop_cnt), 96'(1));
        chk("t5_dual_overflow", 96'(overflow), 96'(1));
        chk("t5_dual_is_wr", 96'(req_is_wr), 96'(1));
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ent(1'b0, 16'h0041, 9'(9'h012 + i), 64'h0));
            push(1'b0, 1'b1, 16'h0041, 9'(9'h012 + i), 64'h0);
        end
        chk("t5_full", 96'(q_count), 96'(8));
        status_clr = 1'b1;
        push(1'b0, 1'b1, 16'h0042, 9'h01F, 64'h0);
        status_clr = 1'b0;
        chk("t5_clr_drop_overflow", 96'(overflow), 96'(1));
        chk("t5_clr_drop_cnt", 96'(drop_cnt), 96'(1));
        wait_drain();

        // ---- 6: drop counter saturation ----
        req_ready = 1'b0;
        status_clr = 1'b1;
        @(posedge clk); #1;
        status_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(ent(1'b0, 16'h0500, 9'(9'h080 + i), 64'h0));
            push(1'b0, 1'b1, 16'h0500, 9'(9'h080 + i), 64'h0);
        end
        rd = 1'b1; addr = 16'h0600; tid = 9'h1FF;
        repeat (65534) @(posedge clk);
        #1;
        chk("t6_drop_fffe", 96'(drop_cnt), 96'(16'hFFFE));
        @(posedge clk); #1;
        chk("t6_drop_ffff", 96'(drop_cnt), 96'(16'hFFFF));
        repeat (70000 - 65535) @(posedge clk);
        #1;
        rd = 1'b0;
        chk("t6_drop_saturated", 96'(drop_cnt), 96'(16'hFFFF));
        chk("t6_overflow", 96'(overflow), 96'(1));
        chk("t6_count", 96'(q_count), 96'(8));
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
